clk_rec_lock_ctrl: RTL

- Acquisition/lock sequencer for the bit clock recovery datapath, clocked by the 300 MHz global clock.
- Takes qualified edge pulses and measured edge intervals from the edge/interval counter.
- Decides when the minimum-interval period estimate is trustworthy, then trims it while locked.
- Drives the period estimate, lock/holdover status and restart pulses to the clock generator and LEDs.

---
 rtl/clk_rec_lock_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/clk_rec_lock_ctrl.sv
// Acquisition/lock sequencer for bit clock recovery: min-interval acquire, verify, trim, holdover.
// Optional lock-loss statistics counter enabled by CLK_REC_LOCK_STATS_EN.
module clk_rec_lock_ctrl #(
  parameter int CLK_LEN       = 32,
  parameter int ACQ_EDGES     = 16,
  parameter int VERIFY_EDGES  = 8,
  parameter int TOL_SHIFT     = 3,
  parameter int MIN_INTERVAL  = 2,
  parameter int LOSS_LIMIT    = 4,
  parameter int TIMEOUT_SHIFT = 2,
  parameter int HOLD_SHIFT    = 4
) (
  input  logic               clk_300M,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               edge_pulse,
  input  logic [CLK_LEN-1:0] interval,
  output logic [CLK_LEN-1:0] period_est,
  output logic               locked,
  output logic               holdover,
  output logic [2:0]         state,
  output logic               lost_pulse,
  output logic               relock_pulse,
  output logic               acq_restart,
  output logic [15:0]        lock_loss_count
);

  localparam int W = CLK_LEN + HOLD_SHIFT;
  localparam logic [CLK_LEN-1:0] MIN_IV    = CLK_LEN'(MIN_INTERVAL);
  localparam logic [CLK_LEN-1:0] ONE       = CLK_LEN'(1);
  localparam logic [15:0]        ACQ_LAST  = 16'(ACQ_EDGES - 1);
  localparam logic [15:0]        VER_LAST  = 16'(VERIFY_EDGES - 1);
  localparam logic [15:0]        LOSS_LAST = 16'(LOSS_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, ACQUIRE = 3'd1, VERIFY = 3'd2, LOCKED = 3'd3, HOLDOVER = 3'd4
  } st_t;

  st_t          st;
  logic [15:0]  stable_cnt, good_cnt, miss_cnt;
  logic [W-1:0] idle_cnt, hold_cnt;

  logic [CLK_LEN-1:0] tol, lo;
  logic [CLK_LEN:0]   hi;
  logic [W-1:0]       to_lim, hold_lim;
  logic               edge_ok, in_lo, in_hi, idle_to, hold_to, go_hold;

  // hi is one bit wider so a near-max estimate cannot wrap the upper bound
  assign tol      = period_est >> TOL_SHIFT;
  assign lo       = period_est - tol;
  assign hi       = {1'b0, period_est} + {1'b0, tol};
  assign in_lo    = interval >= lo;
  assign in_hi    = {1'b0, interval} <= hi;
  assign edge_ok  = edge_pulse && (interval >= MIN_IV);
  assign to_lim   = {{HOLD_SHIFT{1'b0}}, period_est} << TIMEOUT_SHIFT;
  assign hold_lim = {{HOLD_SHIFT{1'b0}}, period_est} << HOLD_SHIFT;
  assign idle_to  = idle_cnt > to_lim;
  assign hold_to  = hold_cnt > hold_lim;
  assign go_hold  = !stop && !start && (st == LOCKED) &&
                    (edge_ok ? (!in_lo && miss_cnt == LOSS_LAST) : idle_to);
  assign state    = st;

  always_ff @(posedge clk_300M or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      period_est   <= '1;
      locked       <= 1'b0;
      holdover     <= 1'b0;
      lost_pulse   <= 1'b0;
      relock_pulse <= 1'b0;
      acq_restart  <= 1'b0;
      stable_cnt   <= '0;
      good_cnt     <= '0;
      miss_cnt     <= '0;
      idle_cnt     <= '0;
      hold_cnt     <= '0;
    end else begin
      lost_pulse   <= 1'b0;
      relock_pulse <= 1'b0;
      acq_restart  <= 1'b0;
      if (edge_ok)              idle_cnt <= '0;
      else if (idle_cnt != '1)  idle_cnt <= idle_cnt + W'(1);
      if (stop) begin
        st         <= IDLE;
        period_est <= '1;
        locked     <= 1'b0;
        holdover   <= 1'b0;
        stable_cnt <= '0;
        good_cnt   <= '0;
        miss_cnt   <= '0;
        idle_cnt   <= '0;
        hold_cnt   <= '0;
      end else if (start) begin
        st          <= ACQUIRE;
        period_est  <= '1;
        locked      <= 1'b0;
        holdover    <= 1'b0;
        acq_restart <= 1'b1;
        stable_cnt  <= '0;
        good_cnt    <= '0;
        miss_cnt    <= '0;
        idle_cnt    <= '0;
        hold_cnt    <= '0;
      end else begin
        case (st)
          ACQUIRE: if (edge_ok) begin
            if (interval < period_est) begin
              period_est <= interval;
              stable_cnt <= '0;
            end else begin
              if (stable_cnt != '1) stable_cnt <= stable_cnt + 16'd1;
              if (stable_cnt == ACQ_LAST) begin
                st       <= VERIFY;
                good_cnt <= '0;
              end
            end
          end
          VERIFY: if (edge_ok) begin
            if (!in_lo) begin
              period_est  <= interval;
              st          <= ACQUIRE;
              stable_cnt  <= '0;
              acq_restart <= 1'b1;
            end else begin
              if (good_cnt != '1) good_cnt <= good_cnt + 16'd1;
              if (good_cnt == VER_LAST) begin
                st       <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end
          end else if (idle_to) begin
            // no edges at all: the estimate is stale, start from scratch
            st          <= ACQUIRE;
            period_est  <= '1;
            stable_cnt  <= '0;
            acq_restart <= 1'b1;
          end
          LOCKED: if (go_hold) begin
            st         <= HOLDOVER;
            locked     <= 1'b0;
            holdover   <= 1'b1;
            lost_pulse <= 1'b1;
            hold_cnt   <= '0;
          end else if (edge_ok) begin
            if (!in_lo) begin
              miss_cnt <= miss_cnt + 16'd1;
            end else begin
              miss_cnt <= '0;
              if (interval < period_est)              period_est <= period_est - ONE;
              else if (in_hi && interval > period_est) period_est <= period_est + ONE;
            end
          end
          HOLDOVER: begin
            if (hold_cnt != '1) hold_cnt <= hold_cnt + W'(1);
            if (edge_ok) begin
              if (in_lo && in_hi) begin
                st           <= LOCKED;
                locked       <= 1'b1;
                holdover     <= 1'b0;
                relock_pulse <= 1'b1;
                miss_cnt     <= '0;
              end
            end else if (hold_to) begin
              st          <= ACQUIRE;
              period_est  <= '1;
              holdover    <= 1'b0;
              stable_cnt  <= '0;
              acq_restart <= 1'b1;
            end
          end
          IDLE:    ;
          default: st <= IDLE;
        endcase
      end
    end
  end

`ifdef CLK_REC_LOCK_STATS_EN
  always_ff @(posedge clk_300M or negedge rst_n) begin
    if (!rst_n)                                  lock_loss_count <= '0;
    else if (go_hold && lock_loss_count != '1)   lock_loss_count <= lock_loss_count + 16'd1;
  end
`else
  assign lock_loss_count = '0;
`endif

endmodule
